// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache that
// sits between the CPU load/store stage and data_memory.
// Lines hold BLOCK_SIZE words; a read miss fetches a whole block from memory,
// and every store is written straight through to memory.
// Optional feature macro: DATA_CACHE_STATS_EN adds the hit_count/miss_count outputs.
module data_cache #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_SIZE  = 16,
    parameter int NUM_LINES   = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WORD_SIZE-1:0]            cpu_addr,
    input  logic [WORD_SIZE-1:0]            cpu_wdata,
    input  logic                            cpu_read,
    input  logic                            cpu_write,
    output logic [WORD_SIZE-1:0]            cpu_rdata,
    output logic                            cpu_stall,
    output logic [WORD_SIZE-1:0]            mem_ptr,
    output logic [WORD_SIZE-1:0]            mem_val,
    output logic                            mem_read_enable,
    output logic                            mem_write_enable,
    input  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_block
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
`endif
);

    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FILL,
        ST_WRITE
    } state_t;

    state_t                state_reg;
    logic [3:0]            lat_cnt_reg;
    logic [NUM_LINES-1:0]  valid_reg;
    logic [TAG_BITS-1:0]   tag_reg [NUM_LINES];

    logic [OFFSET_BITS-1:0] addr_offset;
    logic [INDEX_BITS-1:0]  addr_index;
    logic [TAG_BITS-1:0]    addr_tag;
    logic                   hit;
    logic                   fill_we;
    logic                   store_we;
    logic [WORD_SIZE-1:0]   line_words [BLOCK_SIZE];

    assign addr_offset = cpu_addr[OFFSET_BITS-1:0];
    assign addr_index  = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign addr_tag    = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
    assign hit         = valid_reg[addr_index] && (tag_reg[addr_index] == addr_tag);

    // Line updates are suppressed during reset so an aborted operation leaves no trace.
    assign fill_we  = (state_reg == ST_FILL) && !rst;
    assign store_we = (state_reg == ST_WRITE) && hit && !rst;

    // One storage bank per word position so a fill can write the whole line at once.
    generate
        for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_bank
            logic [WORD_SIZE-1:0] word_reg [NUM_LINES];

            // Fill loads this bank's word of the fetched block; a store hit patches one word.
            always_ff @(posedge clk) begin
                if (fill_we) begin
                    word_reg[addr_index] <= mem_block[(BLOCK_SIZE-gi)*WORD_SIZE-1 -: WORD_SIZE];
                end else if (store_we && (addr_offset == OFFSET_BITS'(gi))) begin
                    word_reg[addr_index] <= cpu_wdata;
                end
            end

            assign line_words[gi] = word_reg[addr_index];
        end
    endgenerate

    // Tags are only rewritten when a fetched block is installed.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_reg[addr_index] <= addr_tag;
        end
    end

    // Controller: idle lookup, block fetch with latency count, fill, and write-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            lat_cnt_reg <= '0;
            valid_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_write) begin
                        state_reg <= ST_WRITE;
                    end else if (cpu_read && !hit) begin
                        state_reg   <= ST_FETCH;
                        lat_cnt_reg <= '0;
                    end
                end
                ST_FETCH: begin
                    lat_cnt_reg <= lat_cnt_reg + 4'd1;
                    if (lat_cnt_reg == LAT_LAST) begin
                        state_reg <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    valid_reg[addr_index] <= 1'b1;
                    state_reg             <= ST_IDLE;
                end
                ST_WRITE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic refill_reg;

    // Counts first-look read hits and idle-to-fetch misses; the re-look after a fill is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            refill_reg <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            refill_reg <= (state_reg == ST_FILL);
            if ((state_reg == ST_IDLE) && cpu_read && !cpu_write) begin
                if (!hit) begin
                    miss_count <= miss_count + 32'd1;
                end else if (!refill_reg) begin
                    hit_count <= hit_count + 32'd1;
                end
            end
        end
    end
`endif

    // Stall decode: a hit returns in the same cycle, misses and stores hold the CPU.
    always_comb begin
        cpu_stall = 1'b0;
        case (state_reg)
            ST_IDLE:  cpu_stall = cpu_write || (cpu_read && !hit);
            ST_FETCH: cpu_stall = 1'b1;
            ST_FILL:  cpu_stall = 1'b1;
            ST_WRITE: cpu_stall = 1'b0;
            default:  cpu_stall = 1'b0;
        endcase
    end

    assign cpu_rdata        = hit ? line_words[addr_offset] : '0;
    assign mem_ptr          = cpu_addr;
    assign mem_val          = cpu_wdata;
    assign mem_read_enable  = (state_reg == ST_FETCH) || (state_reg == ST_FILL);
    assign mem_write_enable = (state_reg == ST_WRITE) && !rst;

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed plus randomized checks of data_cache against a
// line-level reference model (valid/tag per index, flat word memory).
// Build with DATA_CACHE_STATS_EN defined to also check the hit/miss counters.
module tb_data_cache;

    localparam int L = 2;

    logic         clk;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [31:0]  mem_ptr;
    logic [31:0]  mem_val;
    logic         mem_read_enable;
    logic         mem_write_enable;
    logic [511:0] mem_block;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    data_cache #(
        .WORD_SIZE(32), .BLOCK_SIZE(16), .NUM_LINES(8), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_ptr(mem_ptr), .mem_val(mem_val),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .mem_block(mem_block)
`ifdef DATA_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Emulated data_memory storage (written only by DUT strobes) and the reference copy.
    logic [31:0] mem_arr [512];
    logic [31:0] ref_mem [512];
    bit          ref_valid [8];
    logic [24:0] ref_tag [8];
    int          ref_hits = 0;
    int          ref_misses = 0;

    // Addresses use one of four tags so memory can be held in a small array.
    function automatic logic [24:0] tag_of_sel(input int s);
        case (s)
            0: return 25'h0;
            1: return 25'h1;
            2: return 25'h20;
            default: return 25'h1FFFFFF;
        endcase
    endfunction

    function automatic int key_of(input logic [31:0] a);
        for (int s = 0; s < 4; s++) begin
            if (a[31:7] == tag_of_sel(s)) return s * 128 + int'(a[6:0]);
        end
        return -1;
    endfunction

    function automatic logic [31:0] addr_of_key(input int k);
        logic [24:0] t;
        logic [6:0]  low;
        t   = tag_of_sel(k / 128);
        low = 7'(k % 128);
        return {t, low};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int k;
        k = key_of(a);
        if (k < 0) return a + 32'hE0;
        return mem_arr[k];
    endfunction

    // data_memory emulation: block-aligned read presented from the current pointer.
    always @(negedge clk) begin
        logic [31:0] base;
        base = mem_ptr & ~32'hF;
        for (int k = 0; k < 16; k++) begin
            mem_block[(16-k)*32-1 -: 32] <= mem_word(base + 32'(k));
        end
    end

    // data_memory emulation: single-word write strobe.
    always @(posedge clk) begin
        if (mem_write_enable && (key_of(mem_ptr) >= 0)) begin
            mem_arr[key_of(mem_ptr)] <= mem_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        int          idx;
        logic [24:0] tg;
        bit          exp_hit;
        int          stalls, rens, wens;
        bit          done;
        logic [31:0] rd;
        logic [31:0] exp_data;
        idx      = int'(a[6:4]);
        tg       = a[31:7];
        exp_hit  = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_data = ref_mem[key_of(a)];
        cpu_addr  = a;
        cpu_wdata = $urandom;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        stalls = 0; rens = 0; wens = 0; done = 1'b0; rd = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_read_enable === 1'b1) rens++;
            if (mem_write_enable === 1'b1) wens++;
            if (cpu_stall === 1'b0) begin
                done = 1'b1;
                rd   = cpu_rdata;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        cpu_read = 1'b0;
        check("rd_done", 32'(done), 32'd1);
        check("rd_data", rd, exp_data);
        check("rd_stalls", 32'(stalls), exp_hit ? 32'd0 : 32'(L + 2));
        check("rd_ren_cycles", 32'(rens), exp_hit ? 32'd0 : 32'(L + 1));
        check("rd_wen_cycles", 32'(wens), 32'd0);
        if (exp_hit) begin
            ref_hits++;
        end else begin
            ref_misses++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        $display("read  addr=0x%08h data=0x%08h %s stalls=%0d", a, rd, exp_hit ? "hit " : "miss", stalls);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
        int          stalls, rens, wens;
        bit          done;
        logic [31:0] wptr, wval;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        cpu_read  = both;
        stalls = 0; rens = 0; wens = 0; done = 1'b0; wptr = '0; wval = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_read_enable === 1'b1) rens++;
            if (mem_write_enable === 1'b1) begin
                wens++;
                wptr = mem_ptr;
                wval = mem_val;
            end
            if (cpu_stall === 1'b0) done = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        check("wr_done", 32'(done), 32'd1);
        check("wr_stalls", 32'(stalls), 32'd1);
        check("wr_pulses", 32'(wens), 32'd1);
        check("wr_ren_cycles", 32'(rens), 32'd0);
        check("wr_ptr", wptr, a);
        check("wr_val", wval, d);
        ref_mem[key_of(a)] = d;
        $display("write addr=0x%08h data=0x%08h%s", a, d, both ? " (read also high)" : "");
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        for (int k = 0; k < 512; k++) begin
            mem_arr[k] = addr_of_key(k) + 32'hE0;
            ref_mem[k] = addr_of_key(k) + 32'hE0;
        end
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        cpu_addr  = 32'h1234;
        cpu_wdata = 32'hCAFE;

        // Idle outputs straight out of reset.
        @(negedge clk);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_ren", 32'(mem_read_enable), 32'd0);
        check("rst_wen", 32'(mem_write_enable), 32'd0);
        check("rst_ptr", mem_ptr, 32'h1234);
        check("rst_val", mem_val, 32'hCAFE);
`ifdef DATA_CACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Cold miss, hit after fill, store hit, store miss, conflict eviction.
        do_read(32'h25);
        do_read(32'h2A);
        do_write(32'h2A, 32'hDEAD, 1'b0);
        do_read(32'h2A);
        do_write(32'h1000, 32'h55, 1'b0);
        do_read(32'h1000);
        do_read(32'hA0);
        do_read(32'h25);
        do_write(32'h27, 32'h77, 1'b1);
        do_read(32'h27);
`ifdef DATA_CACHE_STATS_EN
        check("dir_hit_count", hit_count, 32'(ref_hits));
        check("dir_miss_count", miss_count, 32'(ref_misses));
`endif

        // Reset while a fetch is in flight.
        cpu_addr = 32'hA5;
        cpu_read = 1'b1;
        @(negedge clk);
        check("mf_idle_stall", 32'(cpu_stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mf_fetch_ren", 32'(mem_read_enable), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cpu_read = 1'b0;
        @(negedge clk);
        check("mf_after_stall", 32'(cpu_stall), 32'd0);
        check("mf_after_ren", 32'(mem_read_enable), 32'd0);
        check("mf_after_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        $display("reset during fetch of 0x000000a5");
        do_read(32'hA5);
        do_read(32'h27);

        // Randomized mix of loads and stores over a few tags and indexes.
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            a = {tag_of_sel(int'($urandom_range(0, 3))), 3'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 9) < 3) do_write(a, $urandom, ($urandom_range(0, 7) == 0));
            else do_read(a);
        end
`ifdef DATA_CACHE_STATS_EN
        check("rand_hit_count", hit_count, 32'(ref_hits));
        check("rand_miss_count", miss_count, 32'(ref_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store stage and data_memory.
- It is the initiator/reader side of the data_memory interface. It drives ptr, val, read_enable and write_enable, and consumes out_block, the 16-word block-aligned read.
- It stalls the CPU on misses and on writes, then returns single words from cached lines.

Parameters:
- WORD_SIZE, 32, bits per word; addresses are word addresses.
- BLOCK_SIZE, 16, words per line; fixed to match the data_memory block; offset = addr[3:0].
- NUM_LINES, 8, number of cache lines; index = addr[6:4]; tag = addr[31:7].
- MEM_LATENCY, 2, cycles mem_read_enable is held before mem_block is sampled (range 1..15).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- cpu_addr  in  WORD_SIZE  word address of the request.
- cpu_wdata  in  WORD_SIZE  store data.
- cpu_read  in  1  load request; held with the same addr until cpu_stall=0.
- cpu_write  in  1  store request; held with the same addr/data until cpu_stall=0.
- cpu_rdata  out  WORD_SIZE  load data; valid when cpu_read=1 and cpu_stall=0.
- cpu_stall  out  1  CPU must hold its request.
- mem_ptr  out  WORD_SIZE  to data_memory ptr.
- mem_val  out  WORD_SIZE  to data_memory val.
- mem_read_enable  out  1  block fetch in progress.
- mem_write_enable  out  1  write strobe, one cycle per store.
- mem_block  in  BLOCK_SIZE*WORD_SIZE  from data_memory out_block. Word k of the block is at bits [(BLOCK_SIZE-k)*WORD_SIZE-1 -: WORD_SIZE], so word 0 is in the MSBs.

Behaviour:
- Storage per line: valid bit, tag, BLOCK_SIZE data words.
- Hit condition: valid[index] && tag match.
- States: IDLE, FETCH, FILL, WRITE.
- Reset (rst=1 at posedge):
  - All valid bits cleared, state=IDLE, latency counter=0.
  - Data and tag arrays are not cleared.
  - Outputs while idle: cpu_stall=0 when no request, cpu_rdata=0 when no hit, mem_read_enable=0, mem_write_enable=0, mem_ptr=cpu_addr, mem_val=cpu_wdata.
- Reset mid-operation aborts the operation. No line is updated and no write strobe is issued in that cycle.
- IDLE, read hit:
  - cpu_stall=0 combinationally in the same cycle; cpu_rdata = line word[offset].
  - 0-cycle hit latency; state stays IDLE.
- IDLE, read miss:
  - cpu_stall=1; next state FETCH; counter loaded to 0.
- FETCH:
  - mem_read_enable=1, mem_ptr=cpu_addr, cpu_stall=1.
  - Counter increments each cycle; when counter==MEM_LATENCY-1, next state is FILL.
- FILL:
  - mem_read_enable=1, cpu_stall=1.
  - At the posedge, mem_block is written into line[index]; tag is set and valid=1.
  - Next state IDLE, where the request now hits.
  - Miss penalty = MEM_LATENCY+1 stall cycles beyond the first.
- IDLE, cpu_write:
  - cpu_stall=1; next state WRITE.
- WRITE:
  - mem_write_enable=1, mem_ptr=cpu_addr, mem_val=cpu_wdata, cpu_stall=0.
  - On hit, the cached word[offset] is updated at the same posedge.
  - On miss, no allocate and the cache is unchanged.
  - Next state IDLE.
- Simultaneous events:
  - cpu_read && cpu_write is illegal; the block treats it as a write.
  - A miss to an index holding a valid line evicts it silently; write-through means there is no writeback.
- mem_write_enable is never asserted in IDLE, FETCH or FILL.
- mem_read_enable is never asserted in IDLE or WRITE.

Optional Feature:
- DATA_CACHE_STATS_EN
  - Defined: adds outputs hit_count and miss_count, each 32 bits, reset to 0.
    - hit_count increments once per completed read that hit on first look in IDLE.
    - miss_count increments on each IDLE->FETCH transition.
    - Both wrap modulo 2^32; writes are not counted.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold read: after rst, read addr 0x25 with memory[0x20..0x2F]=0x100..0x10F → stall for MEM_LATENCY+2 cycles total, rdata=0x105, mem_read_enable high for exactly MEM_LATENCY+1 cycles.
- Hit after fill: read 0x2A immediately after the previous read → stall=0 the same cycle, rdata=0x10A, mem_read_enable stays 0.
- Store hit: write 0x2A←0xDEAD → one mem_write_enable pulse with ptr=0x2A, val=0xDEAD; next read 0x2A hits with 0xDEAD.
- Store miss / conflict: write 0x1000←0x55 (not cached) → write pulse, no fetch. Then read 0xA0 (same index as 0x20, different tag) → miss, refill; the subsequent read of 0x25 misses again.
- Reset mid-fetch: assert rst during FETCH → next cycle state=IDLE, valid cleared, no line written; the re-issued read re-fetches.
- With DATA_CACHE_STATS_EN: run the sequence above → hit_count and miss_count match the reference-model counts (e.g. 1 hit and 2 misses for the first two reads plus the conflict read).
